mv_spi_byte_master: RTL

MV_SPI_BYTE_MASTER -- requirements
Module: mv_spi_byte_master

---
 rtl/mv_spi_byte_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mv_spi_byte_master.sv
// rtl/mv_spi_byte_master.sv - SPI mode-0 byte master with a one-entry request buffer
//
// Full-duplex single-byte SPI master. SCLK half-period is CLK_DIV clocks.
// A transfer runs IDLE -> SHIFT (16*CLK_DIV cycles) -> DONE (one cycle).
// A request arriving while busy is held in a one-entry pending buffer; a
// further request while that buffer is full is dropped and flags overrun.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   wr_data    byte to send, sampled with rw_req
//   rw_req     one-cycle transfer request
//   miso       serial data from slave (synchronous to clock)
//   rd_data    last received byte, held until the next rd_strobe
//   rd_strobe  one-cycle pulse when rd_data is updated
//   ready      idle and pending buffer empty (combinational)
//   overrun    sticky dropped-request flag, cleared by reset only
//   sclk       SPI clock, idle low
//   mosi       serial data to slave, MSB first
module mv_spi_byte_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] wr_data,
  input  logic       rw_req,
  input  logic       miso,
  output logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       ready,
  output logic       overrun,
  output logic       sclk,
  output logic       mosi
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [6:0]  tx_sh;       // transmit bits not yet on mosi
  logic [7:0]  rx_sh;
  logic        pend_v;
  logic [7:0]  pend_data;

  logic        tick, rise, fall, last_fall, start;
  logic [7:0]  load_byte;

  assign tick      = (state == SHIFT) && (div_cnt == DIV_TC);
  assign rise      = tick && !sclk;
  assign fall      = tick && sclk;
  assign last_fall = fall && (bit_cnt == 4'd7);

  // DONE starts the next transfer straight away: from the pending buffer if
  // it is full, otherwise from a request arriving in that very cycle, which
  // would otherwise pass through the empty buffer and be launched next anyway.
  assign start     = ((state == IDLE) && rw_req) ||
                     ((state == DONE) && (pend_v || rw_req));
  assign load_byte = ((state == DONE) && pend_v) ? pend_data : wr_data;

  assign ready     = (state == IDLE) && !pend_v;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rw_req) state_nxt = SHIFT;
      SHIFT:   if (last_fall) state_nxt = DONE;
      DONE:    state_nxt = (pend_v || rw_req) ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= 8'd0;
      bit_cnt   <= 4'd0;
      tx_sh     <= 7'd0;
      rx_sh     <= 8'd0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rd_data   <= 8'h00;
      rd_strobe <= 1'b0;
      pend_v    <= 1'b0;
      pend_data <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;

      if (start) begin
        tx_sh   <= load_byte[6:0];
        mosi    <= load_byte[7];
        div_cnt <= 8'd0;
        bit_cnt <= 4'd0;
        sclk    <= 1'b0;
      end else if (state == SHIFT) begin
        if (tick) begin
          div_cnt <= 8'd0;
          sclk    <= ~sclk;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (rise) begin
          rx_sh <= {rx_sh[6:0], miso};
        end
        if (fall) begin
          mosi    <= tx_sh[6];
          tx_sh   <= {tx_sh[5:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        // The 8th bit was sampled on the preceding rise, so rx_sh is complete.
        if (last_fall) begin
          rd_data   <= rx_sh;
          rd_strobe <= 1'b1;
        end
      end

      if (state == DONE) begin
        pend_v <= 1'b0;
        if (pend_v && rw_req) begin
          overrun <= 1'b1;
        end
      end else if ((state == SHIFT) && rw_req) begin
        if (pend_v) begin
          overrun <= 1'b1;
        end else begin
          pend_v    <= 1'b1;
          pend_data <= wr_data;
        end
      end
    end
  end

endmodule
